peripheral_biu_initiator_tl: RTL and testbench
==============================================

# peripheral_biu_initiator_tl

Bus-functional initiator for the TileLink-style BIU core port: it accepts single read/write commands on a valid/ready command channel, drives one BIU transfer toward a responder such as `peripheral_spram_tl`, and returns read data or error on a valid/ready response channel. It sits between a test sequencer or simple core-side master and any BIU responder. It provides timeout protection so a silent responder cannot hang the requester.

## Interface
- `XLEN`, 64, data width
- `PLEN`, 64, address width
- `TIMEOUT`, 255, max cycles from strobe assertion to `biu_ack_i`/`biu_err_i` before forced error; must be ≥ 2
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  initiator idle, command accepted when `cmd_valid && cmd_ready`
- `cmd_we`  in  1  1 = write, 0 = read
- `cmd_adr`  in  PLEN  byte address
- `cmd_size`  in  3  transfer size (package encoding)
- `cmd_prot`  in  3  protection bits, passed through
- `cmd_lock`  in  1  lock, passed through
- `cmd_data`  in  XLEN  write data
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`
- `rsp_data`  out  XLEN  read data; 0 for writes and errors
- `rsp_err`  out  1  responder error or timeout
- `rsp_timeout`  out  1  error caused by timeout
- `biu_stb_o`  out  1  strobe
- `biu_stb_ack_i`  in  1  strobe accepted
- `biu_d_ack_i`  in  1  write data consumed
- `biu_adri_o`  out  PLEN  address
- `biu_adro_i`  in  PLEN  responder address echo (ignored)
- `biu_size_o`, `biu_type_o`, `biu_prot_o`  out  3 each  size, burst type (always SINGLE), protection
- `biu_lock_o`, `biu_we_o`  out  1 each
- `biu_d_o`  out  XLEN  write data
- `biu_q_i`  in  XLEN  read data
- `biu_ack_i`, `biu_err_i`  in  1 each  transfer acknowledge / error

## Operation
- FSM states: IDLE, REQ, WAIT, RSP.
- IDLE: `cmd_ready`=1. On handshake, register all command fields → REQ.
- REQ: `biu_stb_o`=1 with registered address/we/size/prot/lock/data; `biu_type_o`=SINGLE. Stay until `biu_stb_ack_i`=1 → WAIT; if `biu_ack_i`/`biu_err_i` also high that cycle → RSP directly.
- WAIT: `biu_stb_o`=0; `biu_d_o`/`biu_we_o` held until ack/err. On `biu_err_i` → RSP with err; else on `biu_ack_i` → RSP, capture `biu_q_i` if read.
- `biu_err_i` and `biu_ack_i` same cycle: error wins, `rsp_data`=0.
- `biu_d_ack_i` is informational only; no effect on state.
- Timeout counter: cleared on entry to REQ, increments each cycle in REQ/WAIT; reaching `TIMEOUT` without ack/err → RSP with `rsp_err`=1, `rsp_timeout`=1, strobe dropped.
- RSP: `rsp_valid`=1, fields stable until `rsp_ready` → IDLE.
- Reset at any point: pending transfer discarded, state IDLE.

## Timing
- All outputs registered. Reset values: `cmd_ready`=1, everything else 0 (`biu_type_o`=SINGLE=0).
- Command handshake at cycle N → `biu_stb_o` high at N+1.
- `biu_stb_ack_i` sampled high at cycle M → `biu_stb_o` low at M+1.
- Ack/err sampled at cycle K → `rsp_valid` high at K+1.
- Zero-wait responder (stb_ack and ack in the cycle after stb): command-to-response latency 2 cycles; throughput one transfer per 3 cycles with `rsp_ready` tied high.
- Timeout: strobe rises at cycle S; with no ack, `rsp_valid` rises at S+TIMEOUT.

## Structure
- Package `peripheral_biu_pkg`: size encodings (BYTE=0, HWORD=1, WORD=2, DWORD=3), burst types (SINGLE=0, INCR=1, WRAP=2), protection bit positions, FSM state enum.
- One sub-module: `peripheral_biu_timeout_counter` (clear, enable, `expired` output, width `$clog2(TIMEOUT+1)`).

## Test plan
- Write 0xDEAD_BEEF_0123_4567 to 0x40, size DWORD, against `peripheral_spram_tl` → `biu_stb_o` at N+1, `rsp_valid` with `rsp_err`=0, `rsp_data`=0.
- Read 0x40 afterward → `rsp_data`=0xDEAD_BEEF_0123_4567, `rsp_err`=0.
- Stub responder holds `biu_stb_ack_i` low 5 cycles → strobe and address stable for 6 cycles, then drops next cycle.
- Stub asserts `biu_ack_i` and `biu_err_i` together → `rsp_err`=1, `rsp_data`=0, `rsp_timeout`=0.
- Silent responder, `TIMEOUT`=16 → `rsp_valid` at S+16, `rsp_err`=1, `rsp_timeout`=1, `biu_stb_o`=0.
- Assert `rst` in WAIT, and in RSP with `rsp_ready`=0 → next cycle all outputs at reset values, `cmd_ready`=1.

Source files
------------

// File: rtl/peripheral_biu_pkg.sv
// Shared encodings for the BIU core-port initiator: transfer sizes, burst
// types, protection bit positions and the initiator FSM state.
package peripheral_biu_pkg;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HWORD = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3
  } biu_size_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP   = 3'd2
  } biu_type_t;

  // Bit positions inside the 3-bit protection field.
  localparam int PROT_PRIVILEGED  = 0;
  localparam int PROT_NONSECURE   = 1;
  localparam int PROT_INSTRUCTION = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } biu_state_t;

endpackage

// File: rtl/peripheral_biu_timeout_counter.sv
// Saturating cycle counter used as the transfer watchdog. `expired` is high
// during the TIMEOUT-th enabled cycle after a clear, so the owner can leave
// its waiting state on that edge.
module peripheral_biu_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count enabled cycles, holding at the last value until the next clear.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/peripheral_biu_initiator_tl.sv
// Single-transfer BIU initiator: takes one command on a valid/ready channel,
// runs one SINGLE transfer on the BIU core port, and returns the result on a
// valid/ready response channel. A watchdog forces an error response when the
// responder stays silent.
module peripheral_biu_initiator_tl
  import peripheral_biu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int PLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  // command channel
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [PLEN-1:0] cmd_adr,
  input  logic [2:0]      cmd_size,
  input  logic [2:0]      cmd_prot,
  input  logic            cmd_lock,
  input  logic [XLEN-1:0] cmd_data,
  // response channel
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err,
  output logic            rsp_timeout,
  // BIU core port
  output logic            biu_stb_o,
  input  logic            biu_stb_ack_i,
  input  logic            biu_d_ack_i,
  output logic [PLEN-1:0] biu_adri_o,
  input  logic [PLEN-1:0] biu_adro_i,
  output logic [2:0]      biu_size_o,
  output logic [2:0]      biu_type_o,
  output logic [2:0]      biu_prot_o,
  output logic            biu_lock_o,
  output logic            biu_we_o,
  output logic [XLEN-1:0] biu_d_o,
  input  logic [XLEN-1:0] biu_q_i,
  input  logic            biu_ack_i,
  input  logic            biu_err_i
);

  biu_state_t state;
  logic       expired;
  logic       timer_clear;
  logic       timer_enable;
  logic       accepted;
  logic       done;

  // The address echo and write-data acknowledge carry no information we act on.
  logic unused_biu_inputs;
  assign unused_biu_inputs = ^{biu_adro_i, biu_d_ack_i};

  assign timer_clear  = (state == ST_IDLE) && cmd_valid;
  assign timer_enable = (state == ST_REQ) || (state == ST_WAIT);
  // Ack/err only count once the strobe has been taken (now or earlier).
  assign accepted     = (state == ST_WAIT) || biu_stb_ack_i;
  assign done         = timer_enable && accepted && (biu_ack_i || biu_err_i);

  peripheral_biu_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (expired)
  );

  // Transfer FSM with every port output registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      biu_stb_o   <= 1'b0;
      biu_adri_o  <= '0;
      biu_size_o  <= '0;
      biu_type_o  <= BURST_SINGLE;
      biu_prot_o  <= '0;
      biu_lock_o  <= 1'b0;
      biu_we_o    <= 1'b0;
      biu_d_o     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready  <= 1'b0;
            biu_stb_o  <= 1'b1;
            biu_adri_o <= cmd_adr;
            biu_size_o <= cmd_size;
            biu_type_o <= BURST_SINGLE;
            biu_prot_o <= cmd_prot;
            biu_lock_o <= cmd_lock;
            biu_we_o   <= cmd_we;
            biu_d_o    <= cmd_data;
            state      <= ST_REQ;
          end
        end

        ST_REQ, ST_WAIT: begin
          if (done) begin
            // Error wins over a simultaneous ack and suppresses read data.
            rsp_valid   <= 1'b1;
            rsp_err     <= biu_err_i;
            rsp_timeout <= 1'b0;
            rsp_data    <= (biu_err_i || biu_we_o) ? '0 : biu_q_i;
            biu_stb_o   <= 1'b0;
            biu_we_o    <= 1'b0;
            biu_d_o     <= '0;
            state       <= ST_RSP;
          end else if (expired) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_data    <= '0;
            biu_stb_o   <= 1'b0;
            biu_we_o    <= 1'b0;
            biu_d_o     <= '0;
            state       <= ST_RSP;
          end else if ((state == ST_REQ) && biu_stb_ack_i) begin
            biu_stb_o <= 1'b0;
            state     <= ST_WAIT;
          end
        end

        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            cmd_ready   <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        default: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_biu_initiator_tl.sv
// Directed bench for the BIU initiator. A behavioural responder with
// selectable personalities sits on the BIU port; a transaction-level model
// predicts each response at command acceptance and one compare process
// checks every valid response cycle against it.
module tb_peripheral_biu_initiator_tl;

  localparam int XLEN = 64;
  localparam int PLEN = 64;
  localparam int TMO  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_we = 1'b0;
  logic [PLEN-1:0] cmd_adr = '0;
  logic [2:0]      cmd_size = '0;
  logic [2:0]      cmd_prot = '0;
  logic            cmd_lock = 1'b0;
  logic [XLEN-1:0] cmd_data = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;
  logic            rsp_timeout;
  logic            biu_stb_o;
  logic            biu_stb_ack_i;
  logic            biu_d_ack_i;
  logic [PLEN-1:0] biu_adri_o;
  logic [PLEN-1:0] biu_adro_i;
  logic [2:0]      biu_size_o;
  logic [2:0]      biu_type_o;
  logic [2:0]      biu_prot_o;
  logic            biu_lock_o;
  logic            biu_we_o;
  logic [XLEN-1:0] biu_d_o;
  logic [XLEN-1:0] biu_q_i;
  logic            biu_ack_i;
  logic            biu_err_i;

  peripheral_biu_initiator_tl #(
    .XLEN    (XLEN),
    .PLEN    (PLEN),
    .TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_we        (cmd_we),
    .cmd_adr       (cmd_adr),
    .cmd_size      (cmd_size),
    .cmd_prot      (cmd_prot),
    .cmd_lock      (cmd_lock),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .rsp_timeout   (rsp_timeout),
    .biu_stb_o     (biu_stb_o),
    .biu_stb_ack_i (biu_stb_ack_i),
    .biu_d_ack_i   (biu_d_ack_i),
    .biu_adri_o    (biu_adri_o),
    .biu_adro_i    (biu_adro_i),
    .biu_size_o    (biu_size_o),
    .biu_type_o    (biu_type_o),
    .biu_prot_o    (biu_prot_o),
    .biu_lock_o    (biu_lock_o),
    .biu_we_o      (biu_we_o),
    .biu_d_o       (biu_d_o),
    .biu_q_i       (biu_q_i),
    .biu_ack_i     (biu_ack_i),
    .biu_err_i     (biu_err_i)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checks
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ------------------------------------------------------------- responder
  typedef enum int {M_ZERO, M_DELAY, M_BOTH, M_SILENT, M_HANG} mode_t;
  mode_t mode = M_ZERO;
  int    delay = 0;
  int    stb_hi_cnt;
  logic  in_wait;
  logic [63:0] mem [0:127] = '{default: '0};

  assign biu_adro_i  = biu_adri_o;
  assign biu_d_ack_i = biu_stb_ack_i & biu_we_o;

  always_comb begin
    biu_stb_ack_i = 1'b0;
    biu_ack_i     = 1'b0;
    biu_err_i     = 1'b0;
    biu_q_i       = mem[biu_adri_o[9:3]];
    case (mode)
      M_ZERO:   begin biu_stb_ack_i = biu_stb_o; biu_ack_i = biu_stb_o; end
      M_DELAY:  begin biu_stb_ack_i = biu_stb_o && (stb_hi_cnt >= delay); biu_ack_i = in_wait; end
      M_BOTH:   begin biu_stb_ack_i = biu_stb_o; biu_ack_i = biu_stb_o; biu_err_i = biu_stb_o; end
      M_HANG:   biu_stb_ack_i = biu_stb_o;
      default:  ;
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      stb_hi_cnt <= 0;
      in_wait    <= 1'b0;
    end else begin
      stb_hi_cnt <= biu_stb_o ? stb_hi_cnt + 1 : 0;
      if (biu_stb_o && biu_stb_ack_i && !biu_ack_i && !biu_err_i) in_wait <= 1'b1;
      else if (in_wait && (biu_ack_i || biu_err_i))               in_wait <= 1'b0;
      if (biu_stb_o && biu_stb_ack_i && biu_we_o) mem[biu_adri_o[9:3]] <= biu_d_o;
    end
  end

  // ------------------------------------------------- model and comparison
  typedef struct {
    logic [63:0] data;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model_mem [logic [63:0]];

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          check("rsp_data",    rsp_data,           exp_q[0].data);
          check("rsp_err",     64'(rsp_err),       64'(exp_q[0].err));
          check("rsp_timeout", 64'(rsp_timeout),   64'(exp_q[0].tmo));
          if (rsp_ready) exp_q.delete(0);
        end
      end
      if (cmd_valid && cmd_ready) begin
        e.data = '0; e.err = 1'b0; e.tmo = 1'b0;
        case (mode)
          M_ZERO, M_DELAY: begin
            if (cmd_we) model_mem[cmd_adr] = cmd_data;
            else if (model_mem.exists(cmd_adr)) e.data = model_mem[cmd_adr];
          end
          M_BOTH:  e.err = 1'b1;
          default: begin e.err = 1'b1; e.tmo = 1'b1; end
        endcase
        exp_q.push_back(e);
      end
    end
  end

  // -------------------------------------------------------------- drivers
  task automatic issue(input logic we, input logic [63:0] adr, input logic [2:0] size,
                       input logic [2:0] prot, input logic lock, input logic [63:0] data);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_size = size;
    cmd_prot = prot; cmd_lock = lock; cmd_data = data;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
    if (!cmd_ready) check("cmd_accept_bound", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < budget);
    if (!rsp_valid) check("rsp_wait_bound", 64'(rsp_valid), 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"},   64'(cmd_ready),   64'd1);
    check({tag, "_rsp_valid"},   64'(rsp_valid),   64'd0);
    check({tag, "_rsp_data"},    rsp_data,         64'd0);
    check({tag, "_rsp_err"},     64'(rsp_err),     64'd0);
    check({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
    check({tag, "_stb"},         64'(biu_stb_o),   64'd0);
    check({tag, "_adr"},         biu_adri_o,       64'd0);
    check({tag, "_size"},        64'(biu_size_o),  64'd0);
    check({tag, "_type"},        64'(biu_type_o),  64'd0);
    check({tag, "_prot"},        64'(biu_prot_o),  64'd0);
    check({tag, "_lock"},        64'(biu_lock_o),  64'd0);
    check({tag, "_we"},          64'(biu_we_o),    64'd0);
    check({tag, "_d"},           biu_d_o,          64'd0);
  endtask

  // ----------------------------------------------------------- main flow
  initial begin
    int n, k, hi, neg;
    int hs [3];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Zero-wait write of a doubleword.
    mode = M_ZERO;
    issue(1'b1, 64'h40, 3'd3, 3'b000, 1'b0, 64'hDEAD_BEEF_0123_4567);
    @(negedge clk);
    check("wr_stb_at_n_plus_1", 64'(biu_stb_o),  64'd1);
    check("wr_adr",             biu_adri_o,      64'h40);
    check("wr_size",            64'(biu_size_o), 64'd3);
    check("wr_type_single",     64'(biu_type_o), 64'd0);
    check("wr_d",               biu_d_o,         64'hDEAD_BEEF_0123_4567);
    wait_rsp(40, n);
    check("wr_latency", 64'(n + 1), 64'd2);
    check("wr_rsp_data_literal", rsp_data, 64'd0);
    check("wr_rsp_err_literal",  64'(rsp_err), 64'd0);

    // Read it back.
    issue(1'b0, 64'h40, 3'd3, 3'b000, 1'b0, 64'd0);
    wait_rsp(40, n);
    check("rd_latency", 64'(n), 64'd2);
    check("rd_rsp_data_literal", rsp_data, 64'hDEAD_BEEF_0123_4567);
    check("rd_rsp_err_literal",  64'(rsp_err), 64'd0);

    // Back-to-back reads with rsp_ready tied high: one handshake per 3 cycles.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 64'h40; cmd_size = 3'd3;
    k = 0; neg = 0;
    while (k < 3 && neg < 60) begin
      @(negedge clk); neg++;
      if (cmd_ready) begin
        hs[k] = neg; k++;
        if (k == 3) begin @(posedge clk); #1 cmd_valid = 1'b0; end
      end
    end
    if (k < 3) begin
      check("tput_hs_bound", 64'(k), 64'd3);
      cmd_valid = 1'b0;
    end else begin
      check("tput_gap_0_1", 64'(hs[1] - hs[0]), 64'd3);
      check("tput_gap_1_2", 64'(hs[2] - hs[1]), 64'd3);
    end
    wait_rsp(40, n);

    // Strobe held for 6 cycles while stb_ack is withheld for 5.
    mode = M_DELAY; delay = 5;
    issue(1'b1, 64'h48, 3'd2, 3'b101, 1'b1, 64'h0011_2233_4455_6677);
    @(negedge clk);
    check("dly_prot", 64'(biu_prot_o), 64'd5);
    check("dly_lock", 64'(biu_lock_o), 64'd1);
    check("dly_size", 64'(biu_size_o), 64'd2);
    hi = 0;
    while (biu_stb_o && biu_adri_o == 64'h48 && hi < 30) begin hi++; @(negedge clk); end
    check("dly_stb_cycles", 64'(hi), 64'd6);
    check("dly_stb_dropped", 64'(biu_stb_o), 64'd0);
    check("dly_wait_we_held", 64'(biu_we_o), 64'd1);
    check("dly_wait_d_held", biu_d_o, 64'h0011_2233_4455_6677);
    wait_rsp(40, n);
    check("dly_rsp_err_literal", 64'(rsp_err), 64'd0);

    mode = M_ZERO;
    issue(1'b0, 64'h48, 3'd3, 3'b000, 1'b0, 64'd0);
    wait_rsp(40, n);
    check("dly_readback_literal", rsp_data, 64'h0011_2233_4455_6677);

    // Ack and error together: error wins.
    mode = M_BOTH;
    issue(1'b0, 64'h40, 3'd3, 3'b000, 1'b0, 64'd0);
    wait_rsp(40, n);
    check("both_err_literal",  64'(rsp_err),     64'd1);
    check("both_data_literal", rsp_data,         64'd0);
    check("both_tmo_literal",  64'(rsp_timeout), 64'd0);

    // Silent responder: response TIMEOUT cycles after the strobe rises.
    mode = M_SILENT;
    issue(1'b0, 64'h60, 3'd3, 3'b000, 1'b0, 64'd0);
    @(negedge clk);
    check("tmo_stb_rise", 64'(biu_stb_o), 64'd1);
    k = 0; hi = 1;
    while (!rsp_valid && k < 60) begin
      @(negedge clk); k++;
      if (biu_stb_o) hi++;
    end
    check("tmo_offset",      64'(k),           64'(TMO));
    check("tmo_stb_cycles",  64'(hi),          64'(TMO));
    check("tmo_err_literal", 64'(rsp_err),     64'd1);
    check("tmo_flag",        64'(rsp_timeout), 64'd1);
    check("tmo_stb_low",     64'(biu_stb_o),   64'd0);

    // Reset while waiting for the ack.
    mode = M_HANG;
    issue(1'b1, 64'h58, 3'd3, 3'b000, 1'b0, 64'h5555_AAAA_5555_AAAA);
    repeat (3) @(negedge clk);
    check("hang_in_wait_stb", 64'(biu_stb_o), 64'd0);
    check("hang_in_wait_rsp", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("rst_wait");
    @(posedge clk); #1 rst = 1'b0;

    // Reset while a response is held with rsp_ready low.
    mode = M_ZERO; rsp_ready = 1'b0;
    issue(1'b1, 64'h50, 3'd3, 3'b000, 1'b0, 64'hCAFE_F00D_0000_0050);
    wait_rsp(40, n);
    repeat (3) @(negedge clk);
    check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("rst_rsp");
    @(posedge clk); #1 begin rst = 1'b0; rsp_ready = 1'b1; end

    // Recovery after reset.
    issue(1'b0, 64'h50, 3'd3, 3'b000, 1'b0, 64'd0);
    wait_rsp(40, n);
    check("recover_read_literal", rsp_data, 64'hCAFE_F00D_0000_0050);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
